// File: rtl/sprite_oam_scanner_pkg.sv
// Shared sprite types: OAM entry layout, per-hit config bundle,
// and the OAM-to-config field mapping.
package sprite_oam_scanner_pkg;

    localparam int SPRITE_ROW_UNIT = 8;

    typedef struct packed {
        logic       en;
        logic [7:0] y;
        logic [8:0] x;
        logic [9:0] tile;
        logic [1:0] w;
        logic [1:0] h;
        logic [2:0] palette;
        logic       x_mirror;
        logic       y_mirror;
        logic       fg_prio;
        logic       bg_prio;
    } oam_entry_t;

    typedef struct packed {
        logic [8:0] x;
        logic [1:0] w;
        logic [2:0] palette;
        logic       x_mirror;
        logic       fg_prio;
        logic       bg_prio;
        logic [7:0] y;
        logic [1:0] h;
        logic [9:0] tile;
        logic       y_mirror;
    } sprite_conf_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        HOLD,
        DONE
    } scan_state_t;

    function automatic sprite_conf_t oam_to_conf(input oam_entry_t e);
        sprite_conf_t c;
        c.x        = e.x;
        c.w        = e.w;
        c.palette  = e.palette;
        c.x_mirror = e.x_mirror;
        c.fg_prio  = e.fg_prio;
        c.bg_prio  = e.bg_prio;
        c.y        = e.y;
        c.h        = e.h;
        c.tile     = e.tile;
        c.y_mirror = e.y_mirror;
        return c;
    endfunction

endpackage

// File: rtl/sprite_oam_scanner_row_hit.sv
// Combinational test of one OAM entry against a display row;
// the row offset wraps modulo 256 so sprites can straddle the top.
module sprite_row_hit
    import sprite_oam_scanner_pkg::*;
(
    input  oam_entry_t  entry,
    input  logic [7:0]  row,
    output logic        hit
);

    logic [7:0] offset;
    logic [5:0] limit;

    assign offset = row - entry.y;
    assign limit  = 6'(SPRITE_ROW_UNIT) * (6'(entry.h) + 6'd1);
    assign hit    = entry.en && (offset < {2'b00, limit});

endmodule

// File: rtl/sprite_oam_scanner.sv
// Per-line OAM scanner: walks entries in index order and hands
// each row hit to the fetch logic over a req/ack handshake.
module sprite_oam_scanner
    import sprite_oam_scanner_pkg::*;
#(
    parameter int NUM_SPRITES = 64,
    parameter int ADDR_W      = $clog2(NUM_SPRITES)
) (
    input  logic              clock,
    input  logic              reset_l,
    input  logic              clear,
    input  logic [7:0]        row,
    output logic [ADDR_W-1:0] oam_addr,
    output logic              oam_read,
    input  oam_entry_t        oam_data,
    output sprite_conf_t      conf,
    output logic              conf_exists,
    input  logic              conf_req,
    output logic              conf_ack,
    output logic              scan_done
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_SPRITES - 1);
    localparam logic [ADDR_W:0]   ONE  = (ADDR_W + 1)'(1);

    scan_state_t       state;
    logic [7:0]        row_q;
    logic [ADDR_W:0]   rd_idx;
    logic [ADDR_W-1:0] eval_idx;
    logic              valid;
    logic              hit;
    logic              scan_rd;
    logic              hold_rd;

    sprite_row_hit u_row_hit (
        .entry (oam_data),
        .row   (row_q),
        .hit   (hit)
    );

    // rd_idx carries one extra bit so it can run past the last entry
    assign scan_rd     = (state == SCAN) && !rd_idx[ADDR_W] && !clear;
    assign conf_ack    = (state == HOLD) && conf_req && !clear;
    assign hold_rd     = conf_ack && (eval_idx != LAST);
    assign oam_read    = scan_rd || hold_rd;
    assign oam_addr    = oam_read ? rd_idx[ADDR_W-1:0] : '0;
    assign conf_exists = (state == SCAN) || (state == HOLD);

    always_ff @(posedge clock or negedge reset_l) begin
        if (!reset_l) begin
            state     <= IDLE;
            row_q     <= '0;
            rd_idx    <= '0;
            eval_idx  <= '0;
            valid     <= 1'b0;
            conf      <= '0;
            scan_done <= 1'b0;
        end else begin
            scan_done <= 1'b0;
            if (clear) begin
                state  <= SCAN;
                row_q  <= row;
                rd_idx <= '0;
                valid  <= 1'b0;
                conf   <= '0;
            end else begin
                unique case (state)
                    SCAN: begin
                        valid    <= scan_rd;
                        eval_idx <= rd_idx[ADDR_W-1:0];
                        if (scan_rd)
                            rd_idx <= rd_idx + ONE;
                        if (valid && hit) begin
                            conf     <= oam_to_conf(oam_data);
                            valid    <= 1'b0;
                            eval_idx <= eval_idx;
                            rd_idx   <= {1'b0, eval_idx} + ONE;
                            state    <= HOLD;
                        end else if (valid && eval_idx == LAST) begin
                            valid     <= 1'b0;
                            scan_done <= 1'b1;
                            state     <= DONE;
                        end
                    end
                    HOLD: begin
                        if (conf_ack) begin
                            if (eval_idx == LAST) begin
                                scan_done <= 1'b1;
                                state     <= DONE;
                            end else begin
                                valid    <= 1'b1;
                                eval_idx <= rd_idx[ADDR_W-1:0];
                                rd_idx   <= rd_idx + ONE;
                                state    <= SCAN;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sprite_oam_scanner.sv
// Scoreboard bench for the OAM scanner: expected hit configs are
// queued at each clear and popped on every conf_ack.
module tb_sprite_oam_scanner;
    import sprite_oam_scanner_pkg::*;

    localparam int N  = 64;
    localparam int AW = 6;

    logic          clock    = 1'b0;
    logic          reset_l  = 1'b0;
    logic          clear    = 1'b0;
    logic          conf_req = 1'b0;
    logic [7:0]    row      = 8'd0;
    logic [AW-1:0] oam_addr;
    logic          oam_read;
    oam_entry_t    oam_data = '0;
    sprite_conf_t  conf;
    logic          conf_exists;
    logic          conf_ack;
    logic          scan_done;

    oam_entry_t    mem [N];
    sprite_conf_t  sb [$];
    int            ack_cyc [$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int n_reads, n_ack, n_done, n_exists;
    int first_ack, last_exists, first_exists, reads_after_ack;
    logic          s_read, c1_read;
    logic [AW-1:0] c1_addr;
    sprite_conf_t  s_conf;

    always #5 clock = ~clock;

    sprite_oam_scanner #(.NUM_SPRITES(N)) dut (
        .clock       (clock),
        .reset_l     (reset_l),
        .clear       (clear),
        .row         (row),
        .oam_addr    (oam_addr),
        .oam_read    (oam_read),
        .oam_data    (oam_data),
        .conf        (conf),
        .conf_exists (conf_exists),
        .conf_req    (conf_req),
        .conf_ack    (conf_ack),
        .scan_done   (scan_done)
    );

    always @(posedge clock)
        if (oam_read) oam_data <= mem[oam_addr];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic model_hit(input oam_entry_t e, input int r);
        int d;
        d = (r - int'(e.y)) & 255;
        return e.en && (d < 8 * (int'(e.h) + 1));
    endfunction

    function automatic sprite_conf_t model_conf(input oam_entry_t e);
        sprite_conf_t c;
        c = '0;
        c.x = e.x; c.w = e.w; c.palette = e.palette;
        c.x_mirror = e.x_mirror; c.fg_prio = e.fg_prio;
        c.bg_prio = e.bg_prio; c.y = e.y; c.h = e.h;
        c.tile = e.tile; c.y_mirror = e.y_mirror;
        return c;
    endfunction

    function automatic oam_entry_t rand_entry(input logic en,
                                              input int y, input int h);
        logic [63:0] r64;
        oam_entry_t  e;
        r64  = {$urandom(), $urandom()};
        e    = r64[38:0];
        e.en = en;
        e.y  = 8'(y);
        e.h  = 2'(h);
        return e;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < N; i++) mem[i] = rand_entry(1'b0, 0, 0);
    endtask

    task automatic clear_stats();
        n_reads = 0; n_ack = 0; n_done = 0; n_exists = 0;
        first_ack = -1; last_exists = -1; first_exists = -1;
        reads_after_ack = 0; c1_read = 1'b0; c1_addr = '1;
        ack_cyc.delete();
    endtask

    task automatic sample();
        sprite_conf_t exp;
        s_read = oam_read;
        s_conf = conf;
        if (cyc == 1) begin c1_read = oam_read; c1_addr = oam_addr; end
        if (conf_ack) begin
            n_ack++;
            ack_cyc.push_back(cyc);
            if (first_ack < 0) first_ack = cyc;
            if (sb.size() == 0) begin
                check("extra_ack", 64'(conf_ack), 64'(0));
            end else begin
                exp = sb.pop_front();
                check("conf", 64'(conf), 64'(exp));
            end
        end
        if (oam_read) begin
            n_reads++;
            if (first_ack >= 0) reads_after_ack++;
        end
        if (conf_exists) begin
            n_exists++;
            last_exists = cyc;
            if (first_exists < 0) first_exists = cyc;
        end
        if (scan_done) n_done++;
    endtask

    task automatic step();
        @(negedge clock);
        sample();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic start_line(input int r);
        sb.delete();
        for (int i = 0; i < N; i++)
            if (model_hit(mem[i], r)) sb.push_back(model_conf(mem[i]));
        clear_stats();
        cyc   = 0;
        row   = 8'(r);
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic run_to_done(input int limit);
        int k;
        k = 0;
        while (conf_exists && k < limit) begin
            step();
            k++;
        end
        check("line_timeout", 64'(k < limit), 64'(1));
        step();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_read"}, 64'(oam_read), 64'(0));
        check({tag, "_addr"}, 64'(oam_addr), 64'(0));
        check({tag, "_exists"}, 64'(conf_exists), 64'(0));
        check({tag, "_ack"}, 64'(conf_ack), 64'(0));
        check({tag, "_done"}, 64'(scan_done), 64'(0));
        check({tag, "_conf"}, 64'(conf), 64'(0));
    endtask

    int wrap_rows [3] = '{5, 10, 249};
    int wrap_acks [3] = '{1, 0, 0};

    initial begin
        clear_mem();
        clear_stats();
        #1;
        check_idle_outputs("rst");
        @(posedge clock);
        #1;
        reset_l = 1'b1;

        // single hit on entry 5
        clear_mem();
        mem[5] = rand_entry(1'b1, 8, 0);
        conf_req = 1'b1;
        start_line(10);
        run_to_done(200);
        check("single_ack_cyc", 64'(first_ack), 64'(8));
        check("single_n_ack", 64'(n_ack), 64'(1));
        check("single_reads_after", 64'(reads_after_ack), 64'(58));
        check("single_reads", 64'(n_reads), 64'(65));
        check("single_last_exists", 64'(last_exists), 64'(66));
        check("single_done", 64'(n_done), 64'(1));
        check("single_sb_left", 64'(sb.size()), 64'(0));

        // wrap-around row offsets
        clear_mem();
        mem[0] = rand_entry(1'b1, 250, 1);
        for (int t = 0; t < 3; t++) begin
            start_line(wrap_rows[t]);
            run_to_done(200);
            check($sformatf("wrap_row%0d_acks", wrap_rows[t]),
                  64'(n_ack), 64'(wrap_acks[t]));
            check("wrap_sb_left", 64'(sb.size()), 64'(0));
        end

        // back-to-back hits with a 3-cycle stall
        clear_mem();
        mem[0] = rand_entry(1'b1, 0, 0);
        mem[1] = rand_entry(1'b1, 0, 0);
        conf_req = 1'b0;
        start_line(3);
        while (cyc < 3) step();
        for (int s = 0; s < 3; s++) begin
            step();
            check("stall_read", 64'(s_read), 64'(0));
            check("stall_conf", 64'(s_conf), 64'(model_conf(mem[0])));
        end
        conf_req = 1'b1;
        run_to_done(200);
        check("stall_n_ack", 64'(n_ack), 64'(2));
        if (ack_cyc.size() == 2) begin
            check("stall_ack0_cyc", 64'(ack_cyc[0]), 64'(6));
            check("stall_ack1_cyc", 64'(ack_cyc[1]), 64'(8));
        end

        // empty OAM
        clear_mem();
        start_line(0);
        run_to_done(200);
        check("empty_reads", 64'(n_reads), 64'(64));
        check("empty_acks", 64'(n_ack), 64'(0));
        check("empty_first_exists", 64'(first_exists), 64'(1));
        check("empty_last_exists", 64'(last_exists), 64'(65));
        check("empty_n_exists", 64'(n_exists), 64'(65));
        check("empty_done", 64'(n_done), 64'(1));

        // clear in HOLD together with conf_req
        clear_mem();
        mem[2]  = rand_entry(1'b1, 0, 0);
        mem[10] = rand_entry(1'b1, 18, 0);
        conf_req = 1'b0;
        start_line(3);
        while (cyc < 5) step();
        check("hold_exists", 64'(conf_exists), 64'(1));
        conf_req = 1'b1;
        start_line(20);
        run_to_done(200);
        check("clr_n_ack", 64'(n_ack), 64'(1));
        check("clr_ack_cyc", 64'(first_ack), 64'(13));
        check("clr_c1_read", 64'(c1_read), 64'(1));
        check("clr_c1_addr", 64'(c1_addr), 64'(0));
        check("clr_first_exists", 64'(first_exists), 64'(0));
        check("clr_exists_contig", 64'(n_exists), 64'(last_exists + 1));
        check("clr_sb_left", 64'(sb.size()), 64'(0));

        // async reset in the middle of a scan
        clear_mem();
        conf_req = 1'b0;
        start_line(0);
        while (cyc < 31) step();
        check("pre_rst_addr", 64'(oam_addr), 64'(30));
        #2;
        reset_l = 1'b0;
        #1;
        check_idle_outputs("arst");
        step();
        step();
        reset_l = 1'b1;
        clear_stats();
        for (int i = 0; i < 10; i++) step();
        check("post_rst_reads", 64'(n_reads), 64'(0));
        check("post_rst_exists", 64'(n_exists), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sprite_oam_scanner.md
Name: sprite_oam_scanner

Overview:
- Source side of the sprite-config handshake consumed by the sprite engine's fetch logic.
- On each line `clear`, scans OAM entries 0..NUM_SPRITES-1 in index order through a synchronous-read OAM port, tests each entry against the latched row, and presents hits one at a time on `conf`.
- `conf_exists` is held high until the scanner knows that no further hits remain for the row.

Parameters:
NUM_SPRITES, 64, OAM entry count; power of two, at least 2
ADDR_W, $clog2(NUM_SPRITES), OAM address width

Ports:
clock  in  1  system clock
reset_l  in  1  reset; asynchronous, active-low
clear  in  1  start a new line scan; aborts any scan in progress
row  in  8  line to evaluate; sampled only in the `clear` cycle
oam_addr  out  ADDR_W  OAM read address
oam_read  out  1  OAM read strobe; data returns exactly 1 cycle later
oam_data  in  $bits(oam_entry_t)  OAM read data
conf  out  $bits(sprite_conf_t)  current hit config; stable while holding
conf_exists  out  1  a hit is held, or the scan has not yet finished
conf_req  in  1  consumer requests the next config
conf_ack  out  1  config transferred this cycle
scan_done  out  1  pulses 1 cycle when the scan completes

Behaviour:
- Reset values: all outputs 0; state IDLE; `row_q` 0; conf register 0.
- States:
  - IDLE: reached only from reset.
  - SCAN
  - HOLD
  - DONE
- IDLE and DONE:
  - `conf_exists` = 0, `oam_read` = 0.
  - `clear` moves to SCAN, latches `row` into `row_q`, and resets the read index to 0.
- SCAN:
  - Each cycle, issue `oam_read` = 1 at `oam_addr` = rd_idx, then rd_idx++.
  - A valid flag plus eval_idx track the read in flight.
  - On the cycle after a read, evaluate `oam_data`:
    - hit = en && ((row_q - y) mod 256) < 8*(h+1).
    - Use 8-bit wrapping subtract, compared against a 6-bit extended limit.
  - Hit: load `conf` from the entry's fields (all oam_entry_t fields except `en`), discard the read issued that same cycle, set rd_idx = eval_idx+1, go to HOLD.
  - Miss on eval_idx == NUM_SPRITES-1: go to DONE and pulse `scan_done`.
  - Issue no reads once rd_idx has passed NUM_SPRITES-1.
- HOLD:
  - No reads, except as described below; `conf` is frozen.
  - `conf_ack` = `conf_req` (combinational, HOLD only). Never assert `conf_ack` outside HOLD.
  - On ack with eval_idx < NUM_SPRITES-1: issue a read of rd_idx in the same cycle and return to SCAN, so evaluation resumes the next cycle.
  - On ack of the last entry: go to DONE and pulse `scan_done`.
- `conf_exists` = (state == SCAN or HOLD).
  - This holds through non-hit scan cycles so the consumer waits rather than concluding the line is empty.
- Latency, with `clear` in cycle 0:
  - The read of index k is issued in cycle k+1 and evaluated in cycle k+2.
  - A hit on k is visible on `conf` in cycle k+3.
  - An empty OAM drops `conf_exists` in cycle NUM_SPRITES+2, after exactly NUM_SPRITES reads.
- `clear` in any state, including mid-HOLD or the same cycle as an ack:
  - Takes priority; suppress `conf_ack`; drop the held conf; next state is SCAN at index 0 with the new `row_q`.
  - The in-flight read is discarded. `conf_exists` stays 1.
- No hit-count cap in this block: the consumer stops requesting at its own per-line limit, and the scanner then stays in HOLD until the next `clear`.
- Async reset mid-scan returns to IDLE immediately. No read is issued until the next `clear`.

Decomposition:
- Shared sprite package gains `oam_entry_t` (packed):
  - en 1, y 8, x 9, tile 10, w 2, h 2, palette 3, x_mirror 1, y_mirror 1, fg_prio 1, bg_prio 1 (39 bits).
  - Also a pure function `oam_to_conf(oam_entry_t) -> sprite_conf_t` and the constant `SPRITE_ROW_UNIT` = 8.
- `sprite_conf_t` (existing) must carry x, w, palette, x_mirror, fg_prio, bg_prio, y, h, tile, y_mirror.
- One sub-module: `sprite_row_hit`, combinational (entry, row → hit). It is reused by the debug OAM viewer.

Test Plan:
- Single hit:
  - Stimulus: only entry 5 enabled with y=8, h=0; `clear` with row=10; `conf_req` held high.
  - Response: `conf` valid and `conf_ack` in cycle 8; then 58 further reads; `conf_exists` falls 59 cycles after the ack; `scan_done` pulses once.
- Wrap-around:
  - Entry 0 with y=250, h=1, row=5 → hit.
  - Row=10 → miss (offset 16 ≥ 16).
  - Row=249 → miss.
- Back-to-back hits with stall:
  - Stimulus: entries 0 and 1 hit; `conf_req` low for 3 cycles after entry 0 is held.
  - Response: `conf` stable and `oam_read` low during the stall; entry 1 presented 2 cycles after the first ack.
- Empty OAM:
  - Stimulus: all `en`=0, NUM_SPRITES=64.
  - Response: exactly 64 `oam_read` pulses; `conf_exists` high in cycles 1..65 and low from cycle 66; `conf_ack` never asserted.
- Clear in HOLD:
  - Stimulus: `clear` with row=20 in the same cycle as `conf_req`.
  - Response: no `conf_ack`; `oam_addr`=0 with `oam_read` next cycle; `conf_exists` never drops; hits are evaluated against row 20.
- Reset mid-SCAN:
  - Stimulus: assert `reset_l` low at index 30.
  - Response: all outputs 0 asynchronously; no reads until the next `clear`.
